// File: rtl/bbc_pkg.sv
// rtl/bbc_pkg.sv - shared owner and slot-state encodings for the RAM arbiter
package bbc_pkg;

  // Slot owner encoding, also the value presented on SLOT_OWNER
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VID  = 2'd2,
    OWN_DBG  = 2'd3
  } owner_t;

  // One RAM access per slot: grant, drive address, capture data, acknowledge
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_CAPT = 2'd2,
    ST_ACK  = 2'd3
  } slot_state_t;

endpackage

// File: rtl/bbc_ram_arbiter_if.sv
// rtl/bbc_ram_arbiter_if.sv - requester, slot strobe and RAM bus bundle
interface bbc_ram_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) ();

  logic              RAM_en;
  logic              V_TURN;

  logic              CPU_req;
  logic              CPU_we;
  logic [ADDR_W-1:0] CPU_addr;
  logic [DATA_W-1:0] CPU_wdata;
  logic              CPU_ack;
  logic [DATA_W-1:0] CPU_rdata;

  logic              VID_req;
  logic [ADDR_W-1:0] VID_addr;
  logic              VID_ack;
  logic [DATA_W-1:0] VID_rdata;

  logic              DBG_req;
  logic              DBG_we;
  logic [ADDR_W-1:0] DBG_addr;
  logic [DATA_W-1:0] DBG_wdata;
  logic              DBG_ack;
  logic [DATA_W-1:0] DBG_rdata;

  logic [ADDR_W-1:0] RAM_addr;
  logic [DATA_W-1:0] RAM_wdata;
  logic              RAM_we;
  logic [DATA_W-1:0] RAM_rdata;

  logic [1:0]        SLOT_OWNER;

  // Arbiter side
  modport slave (
    input  RAM_en, V_TURN,
    input  CPU_req, CPU_we, CPU_addr, CPU_wdata,
    output CPU_ack, CPU_rdata,
    input  VID_req, VID_addr,
    output VID_ack, VID_rdata,
    input  DBG_req, DBG_we, DBG_addr, DBG_wdata,
    output DBG_ack, DBG_rdata,
    output RAM_addr, RAM_wdata, RAM_we,
    input  RAM_rdata,
    output SLOT_OWNER
  );

  // Requesters, timing generator and RAM side
  modport master (
    output RAM_en, V_TURN,
    output CPU_req, CPU_we, CPU_addr, CPU_wdata,
    input  CPU_ack, CPU_rdata,
    output VID_req, VID_addr,
    input  VID_ack, VID_rdata,
    output DBG_req, DBG_we, DBG_addr, DBG_wdata,
    input  DBG_ack, DBG_rdata,
    input  RAM_addr, RAM_wdata, RAM_we,
    output RAM_rdata,
    input  SLOT_OWNER
  );

endinterface

// File: rtl/ram_slot_sequencer.sv
// rtl/ram_slot_sequencer.sv - per-slot RAM access FSM and RAM output registers
module ram_slot_sequencer
  import bbc_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              slot_en,
  input  owner_t            win_owner,
  input  logic [ADDR_W-1:0] win_addr,
  input  logic              win_we,
  input  logic [DATA_W-1:0] win_wdata,
  output logic              accept,
  output owner_t            slot_owner,
  output owner_t            acc_owner,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              rd_capture,
  output logic              ack
);

  slot_state_t state_q;
  slot_state_t state_d;
  logic        acc_we;

  // Next state; a strobe is only honoured when no access is in flight
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE, ST_ACK: begin
        if (slot_en) begin
          accept  = 1'b1;
          state_d = (win_owner != OWN_NONE) ? ST_ADDR : ST_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: state_d = ST_CAPT;
      ST_CAPT: state_d = ST_ACK;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Latch the winner's access at grant; write enable lives for the ADDR cycle only
  always_ff @(posedge clk) begin
    if (!resetn) begin
      slot_owner <= OWN_NONE;
      acc_owner  <= OWN_NONE;
      acc_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_we     <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      if (accept) begin
        slot_owner <= win_owner;
        if (win_owner != OWN_NONE) begin
          acc_owner <= win_owner;
          acc_we    <= win_we;
          ram_addr  <= win_addr;
          ram_wdata <= win_wdata;
          ram_we    <= win_we;
        end
      end
    end
  end

  assign rd_capture = (state_q == ST_CAPT) && !acc_we;
  assign ack        = (state_q == ST_ACK);

endmodule

// File: rtl/bbc_ram_arbiter.sv
// rtl/bbc_ram_arbiter.sv - time-division arbiter for the shared main RAM
module bbc_ram_arbiter
  import bbc_pkg::*;
#(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int DBG_STARVE = 8
) (
  input  logic             PIXELCLK,
  input  logic             nRESET,
  bbc_ram_arbiter_if.slave bus
);

  localparam logic [7:0] STARVE_MAX = 8'(DBG_STARVE);

  owner_t            win_owner;
  logic [ADDR_W-1:0] win_addr;
  logic              win_we;
  logic [DATA_W-1:0] win_wdata;
  logic              accept;
  owner_t            slot_owner;
  owner_t            acc_owner;
  logic              rd_capture;
  logic              seq_ack;
  logic [7:0]        starve_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] vid_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  // Slot winner: video slots belong to video alone; CPU slots favour the CPU
  // unless the debug port has been starved long enough
  always_comb begin
    win_owner = OWN_NONE;
    win_addr  = '0;
    win_we    = 1'b0;
    win_wdata = '0;
    if (bus.V_TURN) begin
      if (bus.VID_req) begin
        win_owner = OWN_VID;
        win_addr  = bus.VID_addr;
      end
    end else if (bus.DBG_req && (starve_q == STARVE_MAX)) begin
      win_owner = OWN_DBG;
      win_addr  = bus.DBG_addr;
      win_we    = bus.DBG_we;
      win_wdata = bus.DBG_wdata;
    end else if (bus.CPU_req) begin
      win_owner = OWN_CPU;
      win_addr  = bus.CPU_addr;
      win_we    = bus.CPU_we;
      win_wdata = bus.CPU_wdata;
    end else if (bus.DBG_req) begin
      win_owner = OWN_DBG;
      win_addr  = bus.DBG_addr;
      win_we    = bus.DBG_we;
      win_wdata = bus.DBG_wdata;
    end
  end

  // Count CPU slots the pending debug port has lost; saturates at the threshold
  always_ff @(posedge PIXELCLK) begin
    if (!nRESET) begin
      starve_q <= 8'd0;
    end else if (accept && !bus.V_TURN) begin
      if (!bus.DBG_req || (win_owner == OWN_DBG)) begin
        starve_q <= 8'd0;
      end else if ((win_owner == OWN_CPU) && (starve_q != STARVE_MAX)) begin
        starve_q <= starve_q + 8'd1;
      end
    end
  end

  ram_slot_sequencer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_seq (
    .clk        (PIXELCLK),
    .resetn     (nRESET),
    .slot_en    (bus.RAM_en),
    .win_owner  (win_owner),
    .win_addr   (win_addr),
    .win_we     (win_we),
    .win_wdata  (win_wdata),
    .accept     (accept),
    .slot_owner (slot_owner),
    .acc_owner  (acc_owner),
    .ram_addr   (bus.RAM_addr),
    .ram_wdata  (bus.RAM_wdata),
    .ram_we     (bus.RAM_we),
    .rd_capture (rd_capture),
    .ack        (seq_ack)
  );

  // Per-port read data, updated only by that port's read completions
  always_ff @(posedge PIXELCLK) begin
    if (!nRESET) begin
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else if (rd_capture) begin
      case (acc_owner)
        OWN_CPU: cpu_rdata_q <= bus.RAM_rdata;
        OWN_VID: vid_rdata_q <= bus.RAM_rdata;
        OWN_DBG: dbg_rdata_q <= bus.RAM_rdata;
        default: ;
      endcase
    end
  end

  assign bus.CPU_ack    = seq_ack && (acc_owner == OWN_CPU);
  assign bus.VID_ack    = seq_ack && (acc_owner == OWN_VID);
  assign bus.DBG_ack    = seq_ack && (acc_owner == OWN_DBG);
  assign bus.CPU_rdata  = cpu_rdata_q;
  assign bus.VID_rdata  = vid_rdata_q;
  assign bus.DBG_rdata  = dbg_rdata_q;
  assign bus.SLOT_OWNER = slot_owner;

endmodule

// File: tb/tb_bbc_ram_arbiter.sv
// tb/tb_bbc_ram_arbiter.sv - directed self-checking bench for bbc_ram_arbiter
module tb_bbc_ram_arbiter;

  logic clk;
  logic nreset;
  int   total;
  int   bad;

  bbc_ram_arbiter_if #(.ADDR_W(15), .DATA_W(8)) bus ();

  bbc_ram_arbiter #(
    .ADDR_W     (15),
    .DATA_W     (8),
    .DBG_STARVE (3)
  ) dut (
    .PIXELCLK (clk),
    .nRESET   (nreset),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_own [5];
    total = 0;
    bad   = 0;
    exp_own[0] = 2'd1; exp_own[1] = 2'd1; exp_own[2] = 2'd1;
    exp_own[3] = 2'd3; exp_own[4] = 2'd1;

    nreset        = 1'b0;
    bus.RAM_en    = 1'b0;
    bus.V_TURN    = 1'b0;
    bus.CPU_req   = 1'b0;
    bus.CPU_we    = 1'b0;
    bus.CPU_addr  = '0;
    bus.CPU_wdata = '0;
    bus.VID_req   = 1'b0;
    bus.VID_addr  = '0;
    bus.DBG_req   = 1'b0;
    bus.DBG_we    = 1'b0;
    bus.DBG_addr  = '0;
    bus.DBG_wdata = '0;
    bus.RAM_rdata = '0;
    tick();
    tick();

    // Reset state
    chk("rst_cpu_ack", 32'(bus.CPU_ack), 32'd0);
    chk("rst_vid_ack", 32'(bus.VID_ack), 32'd0);
    chk("rst_dbg_ack", 32'(bus.DBG_ack), 32'd0);
    chk("rst_ram_addr", 32'(bus.RAM_addr), 32'd0);
    chk("rst_ram_wdata", 32'(bus.RAM_wdata), 32'd0);
    chk("rst_ram_we", 32'(bus.RAM_we), 32'd0);
    chk("rst_owner", 32'(bus.SLOT_OWNER), 32'd0);
    chk("rst_cpu_rdata", 32'(bus.CPU_rdata), 32'd0);
    nreset = 1'b1;
    tick();

    // CPU read of 0x1234 returning 0xA5; CPU drops req mid-access
    bus.CPU_req  = 1'b1;
    bus.CPU_we   = 1'b0;
    bus.CPU_addr = 15'h1234;
    bus.RAM_en   = 1'b1;
    bus.V_TURN   = 1'b0;
    tick();
    chk("rd_addr_t1", 32'(bus.RAM_addr), 32'h1234);
    chk("rd_we_t1", 32'(bus.RAM_we), 32'd0);
    chk("rd_owner_t1", 32'(bus.SLOT_OWNER), 32'd1);
    chk("rd_ack_t1", 32'(bus.CPU_ack), 32'd0);
    bus.RAM_en    = 1'b0;
    bus.CPU_req   = 1'b0;
    bus.RAM_rdata = 8'hA5;
    tick();
    chk("rd_ack_t2", 32'(bus.CPU_ack), 32'd0);
    tick();
    chk("rd_ack_t3", 32'(bus.CPU_ack), 32'd1);
    chk("rd_data_t3", 32'(bus.CPU_rdata), 32'hA5);
    tick();
    chk("rd_ack_t4", 32'(bus.CPU_ack), 32'd0);
    chk("rd_data_hold", 32'(bus.CPU_rdata), 32'hA5);

    // Video slot with no video request stays idle even though the CPU asks
    bus.CPU_req  = 1'b1;
    bus.CPU_addr = 15'h0042;
    bus.RAM_en   = 1'b1;
    bus.V_TURN   = 1'b1;
    tick();
    chk("vx_owner", 32'(bus.SLOT_OWNER), 32'd0);
    chk("vx_we", 32'(bus.RAM_we), 32'd0);
    bus.RAM_en = 1'b0;
    tick();
    tick();
    chk("vx_no_ack", 32'(bus.CPU_ack), 32'd0);
    tick();
    bus.RAM_en = 1'b1;
    bus.V_TURN = 1'b0;
    tick();
    chk("vx_cpu_owner", 32'(bus.SLOT_OWNER), 32'd1);
    chk("vx_cpu_addr", 32'(bus.RAM_addr), 32'h0042);
    bus.RAM_en    = 1'b0;
    bus.RAM_rdata = 8'h5A;
    tick();
    tick();
    chk("vx_cpu_ack", 32'(bus.CPU_ack), 32'd1);
    chk("vx_cpu_data", 32'(bus.CPU_rdata), 32'h5A);
    bus.CPU_req = 1'b0;
    tick();

    // Video read wins its own slot over a pending CPU request
    bus.VID_req  = 1'b1;
    bus.VID_addr = 15'h0100;
    bus.CPU_req  = 1'b1;
    bus.CPU_addr = 15'h0200;
    bus.RAM_en   = 1'b1;
    bus.V_TURN   = 1'b1;
    tick();
    chk("vid_owner", 32'(bus.SLOT_OWNER), 32'd2);
    chk("vid_addr", 32'(bus.RAM_addr), 32'h0100);
    chk("vid_we", 32'(bus.RAM_we), 32'd0);
    bus.RAM_en    = 1'b0;
    bus.RAM_rdata = 8'hC3;
    tick();
    tick();
    chk("vid_ack", 32'(bus.VID_ack), 32'd1);
    chk("vid_data", 32'(bus.VID_rdata), 32'hC3);
    chk("vid_cpu_noack", 32'(bus.CPU_ack), 32'd0);
    chk("vid_cpu_data_hold", 32'(bus.CPU_rdata), 32'h5A);
    bus.VID_req = 1'b0;
    bus.CPU_req = 1'b0;
    tick();

    // Debug fill: write 0x3C to 0x7FFF
    bus.DBG_req   = 1'b1;
    bus.DBG_we    = 1'b1;
    bus.DBG_addr  = 15'h7FFF;
    bus.DBG_wdata = 8'h3C;
    bus.RAM_en    = 1'b1;
    bus.V_TURN    = 1'b0;
    tick();
    chk("dbg_we_t1", 32'(bus.RAM_we), 32'd1);
    chk("dbg_addr", 32'(bus.RAM_addr), 32'h7FFF);
    chk("dbg_wdata", 32'(bus.RAM_wdata), 32'h3C);
    chk("dbg_owner", 32'(bus.SLOT_OWNER), 32'd3);
    bus.RAM_en    = 1'b0;
    bus.RAM_rdata = 8'hEE;
    tick();
    chk("dbg_we_t2", 32'(bus.RAM_we), 32'd0);
    tick();
    chk("dbg_ack", 32'(bus.DBG_ack), 32'd1);
    chk("dbg_rdata_keep", 32'(bus.DBG_rdata), 32'h00);
    bus.DBG_req = 1'b0;
    tick();

    // Starvation with threshold 3: CPU, CPU, CPU, DBG, then CPU again
    bus.CPU_req   = 1'b1;
    bus.CPU_we    = 1'b1;
    bus.CPU_addr  = 15'h0010;
    bus.CPU_wdata = 8'h11;
    bus.DBG_req   = 1'b1;
    bus.DBG_we    = 1'b0;
    bus.DBG_addr  = 15'h0020;
    bus.RAM_rdata = 8'h77;
    for (int i = 0; i < 5; i++) begin
      bus.RAM_en = 1'b1;
      bus.V_TURN = 1'b0;
      tick();
      chk($sformatf("stv_owner%0d", i), 32'(bus.SLOT_OWNER), 32'(exp_own[i]));
      bus.RAM_en = 1'b0;
      tick();
      tick();
      chk($sformatf("stv_cpu_ack%0d", i), 32'(bus.CPU_ack), (exp_own[i] == 2'd1) ? 32'd1 : 32'd0);
      chk($sformatf("stv_dbg_ack%0d", i), 32'(bus.DBG_ack), (exp_own[i] == 2'd3) ? 32'd1 : 32'd0);
      tick();
    end
    chk("stv_dbg_rdata", 32'(bus.DBG_rdata), 32'h77);
    bus.CPU_req = 1'b0;
    bus.DBG_req = 1'b0;

    // Stray strobe at t0+2 must be ignored
    bus.CPU_req  = 1'b1;
    bus.CPU_we   = 1'b0;
    bus.CPU_addr = 15'h0333;
    bus.RAM_en   = 1'b1;
    bus.V_TURN   = 1'b0;
    tick();
    bus.RAM_en    = 1'b0;
    bus.RAM_rdata = 8'h9C;
    tick();
    bus.RAM_en  = 1'b1;
    bus.DBG_req = 1'b1;
    tick();
    chk("stray_ack", 32'(bus.CPU_ack), 32'd1);
    chk("stray_data", 32'(bus.CPU_rdata), 32'h9C);
    chk("stray_owner", 32'(bus.SLOT_OWNER), 32'd1);
    bus.RAM_en  = 1'b0;
    bus.DBG_req = 1'b0;
    bus.CPU_req = 1'b0;
    tick();
    chk("stray_ack_end", 32'(bus.CPU_ack), 32'd0);
    chk("stray_no_dbg", 32'(bus.DBG_ack), 32'd0);

    // Reset in the middle of a CPU write
    bus.CPU_req   = 1'b1;
    bus.CPU_we    = 1'b1;
    bus.CPU_addr  = 15'h0444;
    bus.CPU_wdata = 8'h55;
    bus.RAM_en    = 1'b1;
    tick();
    chk("mrst_we_t1", 32'(bus.RAM_we), 32'd1);
    bus.RAM_en = 1'b0;
    nreset     = 1'b0;
    tick();
    chk("mrst_we", 32'(bus.RAM_we), 32'd0);
    chk("mrst_ack", 32'(bus.CPU_ack), 32'd0);
    chk("mrst_owner", 32'(bus.SLOT_OWNER), 32'd0);
    chk("mrst_addr", 32'(bus.RAM_addr), 32'd0);
    chk("mrst_cpu_rdata", 32'(bus.CPU_rdata), 32'd0);
    chk("mrst_vid_rdata", 32'(bus.VID_rdata), 32'd0);
    chk("mrst_dbg_rdata", 32'(bus.DBG_rdata), 32'd0);
    nreset      = 1'b1;
    bus.CPU_req = 1'b0;
    tick();
    chk("mrst_ack_t3", 32'(bus.CPU_ack), 32'd0);
    tick();
    chk("mrst_ack_t4", 32'(bus.CPU_ack), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bbc_ram_arbiter.md
# bbc_ram_arbiter

Time-division arbiter for the shared 32 KiB main RAM. It is driven by the slot strobes from the timing generator (`RAM_en`, `V_TURN`) and grants each 4-cycle RAM slot to one of three requesters: the video fetch path (CRTC/teletext), the 6502 CPU, or a low-priority debug/loader port. It sequences one synchronous-RAM access per slot, returns read data, and acknowledges the owning requester.

## Interface
- `ADDR_W`, 15, RAM address width
- `DATA_W`, 8, RAM data width
- `DBG_STARVE`, 8, consecutive CPU-slot losses after which a pending debug request beats the CPU (range 1..255)

- `PIXELCLK` in 1: sole clock, all logic on rising edge
- `nRESET` in 1: synchronous, active-low reset
- `RAM_en` in 1: slot strobe, one cycle high every 4 `PIXELCLK` cycles
- `V_TURN` in 1: sampled with `RAM_en`; 1 = video slot, 0 = CPU slot
- `CPU_req`, `CPU_we` in 1; `CPU_addr` in ADDR_W; `CPU_wdata` in DATA_W: CPU request
- `CPU_ack` out 1; `CPU_rdata` out DATA_W: completion pulse and read data
- `VID_req` in 1; `VID_addr` in ADDR_W: video read request (read-only port)
- `VID_ack` out 1; `VID_rdata` out DATA_W
- `DBG_req`, `DBG_we` in 1; `DBG_addr` in ADDR_W; `DBG_wdata` in DATA_W: debug/loader request
- `DBG_ack` out 1; `DBG_rdata` out DATA_W
- `RAM_addr` out ADDR_W; `RAM_wdata` out DATA_W; `RAM_we` out 1: RAM drive
- `RAM_rdata` in DATA_W: synchronous RAM output, valid one cycle after address
- `SLOT_OWNER` out 2: owner of current slot (0 none, 1 CPU, 2 VID, 3 DBG)

## Operation
- Requests are level: a requester holds `req` and its address/data stable until its `ack`. Requests are sampled only on cycles with `RAM_en`=1.
- Video slot (`V_TURN`=1): granted to VID if `VID_req`, else the slot is idle. Video slots are never given to CPU or DBG.
- CPU slot (`V_TURN`=0): priority DBG if `DBG_req` and starve count = `DBG_STARVE`; else CPU if `CPU_req`; else DBG if `DBG_req`; else idle.
- Starve counter (8 bit): increments, saturating at `DBG_STARVE`, on each CPU slot where `DBG_req`=1 and CPU wins; clears on DBG grant or when `DBG_req`=0 at a CPU slot.
- Slot FSM states: IDLE -> ADDR -> CAPT -> ACK -> IDLE.
  - IDLE/ACK with `RAM_en`=1 and a winner: latch owner, address, we, wdata; go ADDR. Without a winner: owner 0, go/stay IDLE.
  - ADDR: `RAM_addr`/`RAM_wdata` driven; `RAM_we` = latched we for this cycle only.
  - CAPT: register `RAM_rdata` into owner's rdata register (reads only; writes leave rdata unchanged).
  - ACK: owner's `ack` high for exactly one cycle.
- `RAM_en`=1 while in ADDR or CAPT is ignored (no grant, no abort).
- Requester dropping `req` mid-access: access completes and `ack` still pulses.
- `VID_we` does not exist; video accesses never assert `RAM_we`.

## Timing
- t0 = cycle with `RAM_en`=1. `RAM_addr` valid and `RAM_we` high at t0+1; rdata captured at t0+2 edge; `ack` and new `*_rdata` visible at t0+3; FSM ready for next `RAM_en` at t0+4.
- Access latency request-sampled-to-ack: 3 cycles; at most one access per slot.
- `*_rdata` holds its value until the next read ack of that port.
- `SLOT_OWNER` updates at t0+1, holds until the next `RAM_en` update.
- Reset values: all `ack` 0, all `*_rdata` 0, `RAM_addr` 0, `RAM_wdata` 0, `RAM_we` 0, `SLOT_OWNER` 0, FSM IDLE, starve count 0.
- Reset mid-access: next cycle `RAM_we`=0, no `ack` issued for the aborted access, rdata registers cleared.

## Structure
- Shared package (`bbc_pkg`): owner encoding constants (`OWN_NONE`, `OWN_CPU`, `OWN_VID`, `OWN_DBG`), slot FSM state encoding.
- One sub-module: `ram_slot_sequencer` (IDLE/ADDR/CAPT/ACK FSM plus RAM output registers); arbitration and starve counter stay in the top.

## Test plan
- CPU read: `V_TURN`=0, `CPU_req`=1, addr 0x1234, RAM returns 0xA5 -> `RAM_addr`=0x1234 at t0+1, `CPU_ack` at t0+3, `CPU_rdata`=0xA5.
- Video exclusivity: `V_TURN`=1, `VID_req`=0, `CPU_req`=1 -> slot idle, `RAM_we`=0, `SLOT_OWNER`=0; CPU served at next CPU slot.
- Debug fill: CPU idle, DBG write 0x3C to 0x7FFF -> `RAM_we` high exactly one cycle at t0+1, `DBG_ack` at t0+3, `DBG_rdata` unchanged.
- Starvation: `DBG_STARVE`=3, CPU and DBG requests held continuously -> CPU wins 3 CPU slots, DBG wins the 4th, counter clears.
- Reset mid-access: `nRESET`=0 at t0+1 of CPU write -> `RAM_we`=0 next cycle, no `CPU_ack`, all outputs at reset values.
- Stray strobe: `RAM_en` pulsed at t0+2 -> ignored; original access acks at t0+3.
